// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller: shadows the digit codes, steps
// through the digits at a fixed rate and drives active-low segment/anode lines.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int HEX_MODE   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     dp_en,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic                      lz_en,
    output logic [7:0]                segs,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      scan_tick
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [PRESC_W-1:0]        presc_r;
    logic [IDX_W-1:0]          idx_r;
    logic [4*NUM_DIGITS-1:0]   dig_r;
    logic [NUM_DIGITS-1:0]     dp_r;
    logic [NUM_DIGITS-1:0]     blank_r;
    logic [7:0]                segs_r;
    logic [NUM_DIGITS-1:0]     an_r;
    logic                      tick_r;

    logic                      wrap_s;
    logic [NUM_DIGITS-1:0]     lz_zero_s;
    logic [3:0]                code_s;
    logic                      hide_s;
    logic [7:0]                segs_s;
    logic [NUM_DIGITS-1:0]     an_s;

    // Active-low a..g pattern for one code; dp is handled separately.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'h0:    pat = 7'b0000001;
            4'h1:    pat = 7'b1001111;
            4'h2:    pat = 7'b0010010;
            4'h3:    pat = 7'b0000110;
            4'h4:    pat = 7'b1001100;
            4'h5:    pat = 7'b0100100;
            4'h6:    pat = 7'b0100000;
            4'h7:    pat = 7'b0001111;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0000100;
            4'hA:    pat = (HEX_MODE != 0) ? 7'b0001000 : 7'b0111000;
            4'hB:    pat = (HEX_MODE != 0) ? 7'b1100000 : 7'b0111000;
            4'hC:    pat = (HEX_MODE != 0) ? 7'b0110001 : 7'b0111000;
            4'hD:    pat = (HEX_MODE != 0) ? 7'b1000010 : 7'b0111000;
            4'hE:    pat = (HEX_MODE != 0) ? 7'b0110000 : 7'b0111000;
            4'hF:    pat = 7'b0111000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    assign wrap_s = (presc_r == PRESC_LAST);

    // lz_zero_s[i] is set when shadow digits i..NUM_DIGITS-1 are all zero.
    always_comb begin
        lz_zero_s = '0;
        lz_zero_s[NUM_DIGITS-1] = (dig_r[4*(NUM_DIGITS-1) +: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lz_zero_s[i] = lz_zero_s[i+1] && (dig_r[4*i +: 4] == 4'd0);
        end
    end

    // Next segment/anode pattern for the digit currently selected by idx_r.
    always_comb begin
        code_s = dig_r[4*idx_r +: 4];
        hide_s = blank_r[idx_r] || (lz_en && (idx_r != '0) && lz_zero_s[idx_r]);
        segs_s = hide_s ? 8'hFF : {seg_decode(code_s), ~dp_r[idx_r]};
        an_s   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_s[i] = (idx_r != IDX_W'(i));
        end
    end

    // Prescaler, digit index, shadow registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
            idx_r   <= '0;
            dig_r   <= '0;
            dp_r    <= '0;
            blank_r <= '0;
            segs_r  <= 8'hFF;
            an_r    <= '1;
            tick_r  <= 1'b0;
        end else begin
            if (wrap_s) begin
                presc_r <= '0;
                idx_r   <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
            end else begin
                presc_r <= presc_r + PRESC_W'(1);
                idx_r   <= idx_r;
            end
            if (load) begin
                dig_r   <= digits;
                dp_r    <= dp_en;
                blank_r <= blank;
            end else begin
                dig_r   <= dig_r;
                dp_r    <= dp_r;
                blank_r <= blank_r;
            end
            tick_r <= wrap_s;
            segs_r <= segs_s;
            an_r   <= an_s;
        end
    end

    assign segs      = segs_r;
    assign an        = an_r;
    assign scan_tick = tick_r;

endmodule
